// File: rtl/rr_arbiter_param.sv
// N-way round-robin arbiter with grant hold and bounded tenure.
// Registered one-hot and encoded grant, plus a pulse on forced rotation.
//
// Ports:
//   clk       in  1    clock, all state changes on posedge
//   rst       in  1    synchronous active-high reset
//   req       in  N    request vector, bit i = master i wants the bus
//   gnt       out N    one-hot grant, zero when idle
//   gnt_id    out IDW  encoded grant index, zero when idle
//   gnt_valid out 1    grant present
//   preempt   out 1    current grant came from a tenure-limit rotation
module rr_arbiter_param #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 0,
  parameter int IDW      = $clog2(N),
  parameter int CW       = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           gnt_valid,
  output logic           preempt
);

  localparam bit HOLD_EN = (MAX_HOLD > 0);
  localparam logic [CW-1:0] LIMIT =
    HOLD_EN ? CW'(MAX_HOLD - 1) : '0;

  logic [N-1:0]   gnt_q, gnt_d;
  logic [IDW-1:0] id_q, id_d;
  logic [IDW-1:0] last_q, last_d;
  logic [CW-1:0]  hold_q, hold_d;
  logic           valid_q, valid_d;
  logic           pre_q, pre_d;

  logic           owner_req;
  logic           waiting;
  logic           rotate;
  logic           keep;
  logic           found;
  logic [N-1:0]   elig;
  logic [IDW-1:0] win;
  logic [IDW:0]   sum;
  logic [IDW-1:0] idx;

  always_comb begin
    owner_req = valid_q && req[id_q];
    waiting   = |(req & ~gnt_q);
    rotate    = HOLD_EN && owner_req
                && (hold_q == LIMIT) && waiting;
    keep      = owner_req && !rotate;
    // a rotated-out owner may not win straight back
    elig      = rotate ? (req & ~gnt_q) : req;

    found = 1'b0;
    win   = '0;
    sum   = '0;
    idx   = '0;
    // scan last+1 .. last+N, wrapping mod N
    for (int k = 1; k <= N; k++) begin
      sum = {1'b0, last_q} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(N))
        sum = sum - (IDW+1)'(N);
      idx = sum[IDW-1:0];
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end

    gnt_d   = '0;
    id_d    = '0;
    valid_d = 1'b0;
    pre_d   = 1'b0;
    last_d  = last_q;
    hold_d  = '0;

    if (keep) begin
      gnt_d   = gnt_q;
      id_d    = id_q;
      valid_d = 1'b1;
      if (HOLD_EN && hold_q != LIMIT)
        hold_d = hold_q + CW'(1);
      else
        hold_d = hold_q;
    end else if (found) begin
      gnt_d   = N'(1) << win;
      id_d    = win;
      valid_d = 1'b1;
      last_d  = win;
      pre_d   = rotate;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q   <= '0;
      id_q    <= '0;
      valid_q <= 1'b0;
      pre_q   <= 1'b0;
      last_q  <= IDW'(N - 1);
      hold_q  <= '0;
    end else begin
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      valid_q <= valid_d;
      pre_q   <= pre_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = id_q;
  assign gnt_valid = valid_q;
  assign preempt   = pre_q;

endmodule
